// File: rtl/sdram_arb2.sv
// rtl/sdram_arb2.sv - two-client round-robin arbiter in front of the SDRAM controller port
module sdram_arb2 #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] c0_addr,
  input  logic [DATA_WIDTH-1:0] c0_write_data,
  input  logic                  c0_wr,
  input  logic                  c0_rd,
  output logic                  c0_rdy,
  output logic                  c0_wvalid,
  output logic                  c0_rvalid,
  output logic [DATA_WIDTH-1:0] c0_read_data,
  input  logic [ADDR_WIDTH-1:0] c1_addr,
  input  logic [DATA_WIDTH-1:0] c1_write_data,
  input  logic                  c1_wr,
  input  logic                  c1_rd,
  output logic                  c1_rdy,
  output logic                  c1_wvalid,
  output logic                  c1_rvalid,
  output logic [DATA_WIDTH-1:0] c1_read_data,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_write_data,
  output logic                  m_wr,
  output logic                  m_rd,
  input  logic                  m_rdy,
  input  logic                  m_wvalid,
  input  logic                  m_rvalid,
  input  logic [DATA_WIDTH-1:0] m_read_data
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t state_q, state_d;
  logic   grant_q, grant_d;
  logic   op_wr_q, op_wr_d;
  logic   last_grant_q, last_grant_d;

  logic                  req0, req1;
  logic                  g_wr, g_rd, g_req;
  logic [ADDR_WIDTH-1:0] g_addr;
  logic [DATA_WIDTH-1:0] g_wdata;
  logic                  g_rdy, g_wvalid, g_rvalid;

  always_comb begin
    req0    = c0_wr | c0_rd;
    req1    = c1_wr | c1_rd;
    g_wr    = grant_q ? c1_wr : c0_wr;
    g_rd    = grant_q ? c1_rd : c0_rd;
    g_req   = g_wr | g_rd;
    g_addr  = grant_q ? c1_addr : c0_addr;
    g_wdata = grant_q ? c1_write_data : c0_write_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      grant_q      <= 1'b0;
      op_wr_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      op_wr_q      <= op_wr_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    op_wr_d      = op_wr_q;
    last_grant_d = last_grant_q;
    m_addr       = '0;
    m_write_data = '0;
    m_wr         = 1'b0;
    m_rd         = 1'b0;
    g_rdy        = 1'b0;
    g_wvalid     = 1'b0;
    g_rvalid     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req0 | req1) begin
          grant_d = (req0 & req1) ? ~last_grant_q : req1;
          op_wr_d = grant_d ? c1_wr : c0_wr;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        m_addr       = g_addr;
        m_write_data = g_wdata;
        // Strobes are gated by the live request so a withdrawn request never reaches the controller.
        if (!g_req) begin
          state_d = S_IDLE;
        end else begin
          m_wr  = op_wr_q;
          m_rd  = ~op_wr_q;
          g_rdy = m_rdy;
          if (m_rdy) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        g_wvalid = op_wr_q & m_wvalid;
        g_rvalid = ~op_wr_q & m_rvalid;
        if (g_wvalid | g_rvalid) begin
          last_grant_d = grant_q;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign c0_rdy       = g_rdy & ~grant_q;
  assign c1_rdy       = g_rdy & grant_q;
  assign c0_wvalid    = g_wvalid & ~grant_q;
  assign c1_wvalid    = g_wvalid & grant_q;
  assign c0_rvalid    = g_rvalid & ~grant_q;
  assign c1_rvalid    = g_rvalid & grant_q;
  assign c0_read_data = m_read_data;
  assign c1_read_data = m_read_data;

endmodule

// File: doc/sdram_arb2.md
# sdram_arb2

Two-client request arbiter sitting directly upstream of the SDRAM core controller's control port. Each client drives the same addr/wr/rd/write_data handshake the controller exposes and receives rdy/wvalid/rvalid/read_data back. The arbiter grants one client at a time round-robin, forwards its request to the controller, and routes the completion pulse back to the granted client. Exactly one transaction is outstanding at the controller.

## Interface
- ADDR_WIDTH, 32, byte address width on client and controller side
- DATA_WIDTH, 32, data word width
- clk  in  1  single clock for all logic
- rst  in  1  synchronous, active-high reset
- cN_addr  in  ADDR_WIDTH  client N request address (N = 0, 1)
- cN_write_data  in  DATA_WIDTH  client N write data
- cN_wr  in  1  client N write request, held until cN_rdy seen
- cN_rd  in  1  client N read request, held until cN_rdy seen
- cN_rdy  out  1  request accepted this cycle
- cN_wvalid  out  1  one-cycle write-complete pulse
- cN_rvalid  out  1  one-cycle read-data-valid pulse
- cN_read_data  out  DATA_WIDTH  read data, valid when cN_rvalid
- m_addr, m_write_data  out  ADDR_WIDTH / DATA_WIDTH  to controller
- m_wr, m_rd  out  1  to controller request strobes
- m_rdy  in  1  controller accepts request
- m_wvalid, m_rvalid  in  1  controller completion pulses
- m_read_data  in  DATA_WIDTH  controller read data

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE: req_N = cN_wr | cN_rd. If only one client requests, grant it. If both, grant the client other than last_grant. Register grant, op (WRITE if cN_wr, else READ; wr wins if both set). Go ISSUE. No request: stay.
- ISSUE: m_addr, m_write_data live-muxed from granted client; m_wr = (op==WRITE), m_rd = (op==READ); never both. cG_rdy = m_rdy (combinational, granted client only). Edge with m_rdy=1: go WAIT. Granted client drops both wr and rd before m_rdy: cancel, return IDLE, last_grant unchanged.
- WAIT: m_wr = m_rd = 0. op WRITE: cG_wvalid = m_wvalid; op READ: cG_rvalid = m_rvalid. Edge with matching valid: last_grant <= G, go IDLE. Non-matching valid ignored.
- cN_read_data = m_read_data for both clients at all times.
- Outside ISSUE, m_addr and m_write_data drive 0.
- m_wvalid/m_rvalid outside WAIT ignored, never forwarded.
- Non-granted client sees rdy/wvalid/rvalid = 0; its request stays pending.

## Timing
- Reset: state IDLE, last_grant = 1 (client 0 wins first tie), grant = 0, op = READ. All outputs 0: m_wr, m_rd, m_addr, m_write_data, cN_rdy, cN_wvalid, cN_rvalid. cN_read_data follows m_read_data.
- rst asserted in any state: IDLE on the next edge, in-flight transaction dropped without a completion pulse.
- Arbitration latency: request visible before edge E (in IDLE) -> m_wr/m_rd high in cycle after E.
- cG_rdy, cG_wvalid, cG_rvalid same cycle as controller signal (zero latency).
- After completion edge: IDLE for one cycle, then next grant. Back-to-back minimum: 1 idle cycle between m_rdy-accept sequences per completion.
- Fairness: with both clients continuously requesting, grants strictly alternate 0,1,0,1.
- Client changes addr/data while waiting for rdy: passed through unchanged (no latching).

## Test plan
- Reset, c0 write addr 0x14 data 0x5: m_wr high from cycle after request, m_addr=0x14, m_write_data=0x5; c0_rdy mirrors m_rdy; c0_wvalid pulses with m_wvalid; c1 outputs stay 0.
- c1 read addr 0x400, controller returns 0xFFFA0005: c1_rvalid one cycle, c1_read_data=0xFFFA0005; c0_rvalid 0.
- c0 and c1 request same cycle from reset, both held: grants order c0, c1, c0, c1 over four transactions; one idle cycle between each completion and next m_wr/m_rd.
- c0 asserts wr and rd together: only m_wr asserted; completion only via m_wvalid; stray m_rvalid in WAIT ignored, state stays WAIT.
- rst pulsed while in WAIT: next cycle IDLE, all outputs 0; late m_wvalid ignored; last_grant=1 so a tie grants c0.
- Granted c1 drops rd in ISSUE before m_rdy: returns IDLE, no rdy pulse to c1; pending c0 granted next.
